// File: rtl/hexscan_pkg.sv
// Shared types and nibble helpers for the hex digit scanner.
// HEXSCAN_LZB_EN adds the leading-zero blanking helper.
package hexscan_pkg;

   localparam int NIBBLE_W   = 4;
   localparam int MAX_DIGITS = 16;
   localparam int VALUE_W    = NIBBLE_W * MAX_DIGITS;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      GAP  = 2'd1,
      SHOW = 2'd2
   } scan_state_t;

   // Callers zero-extend their packed value to VALUE_W bits.
   function automatic logic [NIBBLE_W-1:0] nibble_at(input logic [VALUE_W-1:0] value,
                                                     input int idx);
      return value[idx*NIBBLE_W +: NIBBLE_W];
   endfunction

`ifdef HEXSCAN_LZB_EN
   // True when nibble idx and every more significant nibble are zero.
   function automatic logic lz_blank(input logic [VALUE_W-1:0] value,
                                     input int idx);
      logic any_set;
      any_set = 1'b0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i >= idx) any_set = any_set | (|value[i*NIBBLE_W +: NIBBLE_W]);
      end
      return !any_set;
   endfunction
`endif

endpackage

// File: rtl/scan_prescaler.sv
// Free-running slot prescaler: pulses tick once every SCAN_DIV cycles.
module scan_prescaler #(
   parameter int SCAN_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CNT_W = $clog2(SCAN_DIV);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick  = (cnt_q == CNT_W'(SCAN_DIV - 1));
   assign cnt_d = tick ? '0 : cnt_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/hex_digit_scanner.sv
// Multiplexed common-anode seven-segment scanner with a dark gap cycle between digits.
// Define HEXSCAN_LZB_EN to enable leading-zero blanking.
module hex_digit_scanner
   import hexscan_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [4*NUM_DIGITS-1:0]       value_in,
   input  logic                          load,
   output logic [3:0]                    hex,
   output logic [NUM_DIGITS-1:0]         digit_sel_n,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

   localparam int IDX_W = $clog2(NUM_DIGITS);

   logic                    tick;
   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
   logic [VALUE_W-1:0]      shadow_ext;
   scan_state_t             state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d, idx_nxt;
   logic [NIBBLE_W-1:0]     hex_q, hex_d;
   logic [NUM_DIGITS-1:0]   sel_q, sel_d;
`ifdef HEXSCAN_LZB_EN
   logic                    blank_q, blank_d;
`endif

   scan_prescaler #(
      .SCAN_DIV(SCAN_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick)
   );

   assign shadow_d = load ? value_in : shadow_q;

   always_comb begin
      shadow_ext                     = '0;
      shadow_ext[4*NUM_DIGITS-1:0]   = shadow_q;
   end

   assign idx_nxt = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

   // hex and blanking sample shadow_q, so a load on the tick edge shows from the next slot.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hex_d   = hex_q;
      sel_d   = sel_q;
`ifdef HEXSCAN_LZB_EN
      blank_d = blank_q;
`endif
      case (state_q)
         OFF, SHOW: begin
            if (tick) begin
               state_d = GAP;
               sel_d   = '1;
               idx_d   = idx_nxt;
               hex_d   = nibble_at(shadow_ext, int'(idx_nxt));
`ifdef HEXSCAN_LZB_EN
               blank_d = (idx_nxt != '0) && lz_blank(shadow_ext, int'(idx_nxt));
`endif
            end
         end
         GAP: begin
            state_d = SHOW;
`ifdef HEXSCAN_LZB_EN
            sel_d   = blank_q ? '1 : ~(NUM_DIGITS'(1) << idx_q);
`else
            sel_d   = ~(NUM_DIGITS'(1) << idx_q);
`endif
         end
         default: begin
            state_d = OFF;
            sel_d   = '1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         state_q  <= OFF;
         idx_q    <= IDX_W'(NUM_DIGITS - 1);
         hex_q    <= '0;
         sel_q    <= '1;
`ifdef HEXSCAN_LZB_EN
         blank_q  <= 1'b0;
`endif
      end else begin
         shadow_q <= shadow_d;
         state_q  <= state_d;
         idx_q    <= idx_d;
         hex_q    <= hex_d;
         sel_q    <= sel_d;
`ifdef HEXSCAN_LZB_EN
         blank_q  <= blank_d;
`endif
      end
   end

   assign hex         = hex_q;
   assign digit_sel_n = sel_q;
   assign digit_idx   = idx_q;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed bench for hex_digit_scanner with NUM_DIGITS=4, SCAN_DIV=4.
module tb_hex_digit_scanner;

   logic        clk;
   logic        rst_n;
   logic [15:0] value_in;
   logic        load;
   logic [3:0]  hex;
   logic [3:0]  digit_sel_n;
   logic [1:0]  digit_idx;

   int total = 0;
   int bad   = 0;

`ifdef HEXSCAN_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   hex_digit_scanner #(
      .NUM_DIGITS(4),
      .SCAN_DIV  (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value_in   (value_in),
      .load       (load),
      .hex        (hex),
      .digit_sel_n(digit_sel_n),
      .digit_idx  (digit_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, want);
      end
   endtask

   // Every step ends on a falling edge; a load pulse lasts exactly one rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         load = 1'b0;
      end
   endtask

   task automatic pulse_load(input logic [15:0] v);
      value_in = v;
      load     = 1'b1;
   endtask

   task automatic chk_dark(input string tag);
      chk({tag, "_sel"}, {12'h0, digit_sel_n}, 16'h000F);
   endtask

   // One full slot: GAP cycle then three SHOW cycles.
   task automatic run_slot(input logic [1:0] d, input logic [3:0] want_hex,
                           input logic [3:0] want_sel);
      step(1);
      chk("gap_idx", {14'h0, digit_idx}, {14'h0, d});
      chk("gap_hex", {12'h0, hex}, {12'h0, want_hex});
      chk_dark("gap");
      step(1);
      chk("show_sel_first", {12'h0, digit_sel_n}, {12'h0, want_sel});
      chk("show_hex_first", {12'h0, hex}, {12'h0, want_hex});
      step(2);
      chk("show_sel_last", {12'h0, digit_sel_n}, {12'h0, want_sel});
      chk("show_hex_last", {12'h0, hex}, {12'h0, want_hex});
   endtask

   logic [3:0] prev_sel = 4'hF;
   logic [3:0] prev_hex = 4'h0;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("onehot", {15'h0, ($countones(~digit_sel_n) <= 1)}, 16'h0001);
         if (digit_sel_n != 4'hF && digit_sel_n == prev_sel)
            chk("hex_stable", {12'h0, hex}, {12'h0, prev_hex});
      end
      prev_sel = digit_sel_n;
      prev_hex = hex;
   end

   initial begin
      rst_n    = 1'b0;
      load     = 1'b0;
      value_in = 16'h0;

      // Reset held: inputs toggle, outputs must stay at reset values.
      for (int i = 0; i < 3; i++) begin
         value_in = 16'hFFFF ^ 16'(i * 16'h1111);
         load     = 1'b1;
         @(negedge clk);
         chk("rst_hex", {12'h0, hex}, 16'h0000);
         chk_dark("rst");
         chk("rst_idx", {14'h0, digit_idx}, 16'h0003);
      end

      // Release reset together with a load of 1A2F.
      rst_n = 1'b1;
      pulse_load(16'h1A2F);
      for (int i = 1; i <= 3; i++) begin
         step(1);
         chk_dark("post_rst");
         chk("post_rst_idx", {14'h0, digit_idx}, 16'h0003);
      end

      // Two frames, including the wrap from digit 3 back to digit 0.
      for (int f = 0; f < 2; f++) begin
         run_slot(2'd0, 4'hF, 4'b1110);
         run_slot(2'd1, 4'h2, 4'b1101);
         run_slot(2'd2, 4'hA, 4'b1011);
         run_slot(2'd3, 4'h1, 4'b0111);
      end

      // Loads coinciding with the tick: the new slot shows the old shadow.
      run_slot(2'd0, 4'hF, 4'b1110);
      pulse_load(16'h1234);
      run_slot(2'd1, 4'h2, 4'b1101);
      pulse_load(16'hBEEF);
      run_slot(2'd2, 4'h2, 4'b1011);
      run_slot(2'd3, 4'hB, 4'b0111);
      run_slot(2'd0, 4'hF, 4'b1110);
      run_slot(2'd1, 4'hE, 4'b1101);

      // Short asynchronous reset pulse in the middle of a SHOW slot.
      step(2);
      chk("pre_pulse_sel", {12'h0, digit_sel_n}, 16'h000B);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_hex", {12'h0, hex}, 16'h0000);
      chk_dark("async");
      chk("async_idx", {14'h0, digit_idx}, 16'h0003);
      rst_n = 1'b1;
      pulse_load(16'h0030);
      for (int i = 1; i <= 3; i++) begin
         step(1);
         chk_dark("restart");
      end
      run_slot(2'd0, 4'h0, 4'b1110);
      run_slot(2'd1, 4'h3, 4'b1101);
      run_slot(2'd2, 4'h0, LZB ? 4'b1111 : 4'b1011);
      run_slot(2'd3, 4'h0, LZB ? 4'b1111 : 4'b0111);
      run_slot(2'd0, 4'h0, 4'b1110);

      // All-zero value loaded on the tick into digit 1: that slot uses 0030.
      pulse_load(16'h0000);
      run_slot(2'd1, 4'h3, 4'b1101);
      run_slot(2'd2, 4'h0, LZB ? 4'b1111 : 4'b1011);
      run_slot(2'd3, 4'h0, LZB ? 4'b1111 : 4'b0111);
      run_slot(2'd0, 4'h0, 4'b1110);
      run_slot(2'd1, 4'h0, LZB ? 4'b1111 : 4'b1101);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hex_digit_scanner.md
Name: hex_digit_scanner

Overview:
- Time-multiplexed scanner for a multi-digit common-anode seven-segment display.
- Captures a packed hex value on a load strobe into a shadow register.
- Steps through one digit at a time. Presents that digit's nibble on hex, which feeds the downstream hex-to-seven-segment decoder, and drives one active-low digit enable.
- Inserts a one-cycle all-dark gap between digits to suppress ghosting.

Parameters:
- NUM_DIGITS, 4: number of display digits and nibbles; must be >= 2.
- SCAN_DIV, 50000: clock cycles per digit slot, gap cycle included; must be >= 2.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- value_in  input  4*NUM_DIGITS  packed hex value; nibble i drives digit i, digit 0 is least significant.
- load  input  1  single-cycle strobe; captures value_in into the shadow register.
- hex  output  4  nibble for the digit in the current slot; goes to the downstream decoder.
- digit_sel_n  output  NUM_DIGITS  active-low one-hot digit enable; all ones means dark.
- digit_idx  output  $clog2(NUM_DIGITS)  index of the current or next digit.

Behaviour:
- Reset (asynchronous, rst_n=0): takes effect immediately, not at a clock edge. Values while reset is held:
  - shadow = 0, prescaler cnt = 0
  - digit_idx = NUM_DIGITS-1
  - state = OFF
  - hex = 4'h0, digit_sel_n = all ones
- Prescaler:
  - cnt is $clog2(SCAN_DIV) bits and increments every cycle.
  - tick = (cnt == SCAN_DIV-1); on that edge cnt wraps to 0.
- Shadow register: on the edge where load=1, shadow <= value_in. Otherwise the shadow holds its value.
- State machine has three states: OFF, GAP, SHOW.
  - OFF: reset-only state; leaves on the first tick.
  - On any edge where tick=1, from OFF or SHOW:
    - state <= GAP
    - digit_sel_n <= all ones
    - digit_idx <= digit_idx+1, wrapping NUM_DIGITS-1 to 0
    - hex <= shadow nibble at the new digit_idx
  - GAP to SHOW on the next edge, unconditionally. digit_sel_n[digit_idx] <= 0; all other bits stay 1.
  - SHOW: hex and digit_sel_n hold until the next tick.
- Timing:
  - Each slot lasts SCAN_DIV cycles: 1 GAP cycle plus SCAN_DIV-1 SHOW cycles.
  - The first lit digit is digit 0, enabled SCAN_DIV+1 cycles after rst_n deasserts.
  - A full frame lasts NUM_DIGITS*SCAN_DIV cycles.
- Simultaneous load and tick on the same edge: hex samples the OLD shadow. The new value appears from the next slot onward. No partial or torn nibble is ever displayed.
- hex changes only on GAP entry; it is stable through GAP and SHOW.
- At most one bit of digit_sel_n is 0 in any cycle.
- load while in OFF: the shadow is updated; nothing is displayed until the first tick.

Optional Feature:
- Macro: HEXSCAN_LZB_EN (leading-zero blanking).
- Defined:
  - On GAP entry to digit k > 0, compute blank_k = (shadow nibbles k..NUM_DIGITS-1 are all zero), using the old shadow as above.
  - If blank_k, the following SHOW keeps digit_sel_n all ones for the whole slot. hex is still loaded normally.
  - Digit 0 is never blanked.
  - Slot timing is unchanged.
- Undefined: every digit is lit in its slot; no blanking logic is present.

Decomposition:
- Package hexscan_pkg:
  - scan_state_t enum {OFF, GAP, SHOW}
  - localparam NIBBLE_W = 4
  - function nibble_at(value, idx)
  - function lz_blank(value, idx), compiled only under HEXSCAN_LZB_EN
- Sub-module scan_prescaler:
  - Parameter: SCAN_DIV. Ports: clk, rst_n, tick.
  - Free-running counter with an asynchronous active-low clear.
- The top level holds the shadow register, FSM, index counter and output registers.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4 unless stated):
- Reset: hold rst_n=0 and toggle value_in/load -> hex=0, digit_sel_n=4'b1111, digit_idx=3. After release, outputs stay dark for 4 cycles; digit_sel_n=4'b1110 on cycle 5.
- Load 16'h1A2F then run 2 frames:
  - hex sequence F,2,A,1,F,2,A,1.
  - digit_sel_n goes 1111 (1 cycle) then 1110/1101/1011/0111, each for 3 cycles.
  - Wrap from digit 3 back to digit 0 is checked.
- load 16'hBEEF on the same edge as the tick into digit 2, with old value 16'h1234 -> digit 2 shows 2 (old value); digits 3, 0, 1 then show B, F, E.
- Pulse rst_n low for 1 ns mid-SHOW -> digit_sel_n is all ones and hex=0 immediately (asynchronous), and the post-release sequence restarts at digit 0.
- HEXSCAN_LZB_EN defined:
  - value 16'h0030 -> digits 3 and 2 dark for their full slots; digit 1 shows 3; digit 0 shows 0.
  - value 16'h0000 -> only digit 0 lit.
  - With the macro undefined, all four digits are lit.
- Assertion throughout: $countones(~digit_sel_n) <= 1, and hex is stable whenever any digit is enabled.
